div_unit: RTL and testbench

//  Multi-cycle radix-2 restoring divider. Serves the div_start/div_opdata/signed_div

---
 rtl/div_unit_pkg.sv | 18 +
 rtl/div_unit_if.sv | 29 ++
 rtl/div_unit.sv | 117 +++++++++++
 tb/tb_div_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared types and widths for the multi-cycle restoring divider.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
`timescale 1ns/1ps
package div_unit_pkg;

  localparam int DIV_DATA_W = 32;  // operand width; result is twice this
  localparam int DIV_CNT_W  = 6;   // iteration counter, must be able to hold DIV_DATA_W

  // Divider control states
  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,  // idle, waiting for a request
    DIV_BYZERO = 2'b01,  // divisor was zero, result forced to 0
    DIV_ON     = 2'b10,  // shift-subtract iterations in progress
    DIV_END    = 2'b11   // result presented until the requester drops start
  } div_state_t;

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between the EX stage (master) and the divider (slave).
// Latency: n/a (wires only).
// Backpressure: start_i is held by the master until ready_o is seen.
// Signals: start_i, annul_i, signed_div_i, opdata1_i, opdata2_i (master -> slave),
//          result_o {remainder, quotient}, ready_o (slave -> master).
`timescale 1ns/1ps
interface div_unit_if #(
  parameter int DATA_W = div_unit_pkg::DIV_DATA_W
);

  logic                start_i;
  logic                annul_i;
  logic                signed_div_i;
  logic [DATA_W-1:0]   opdata1_i;
  logic [DATA_W-1:0]   opdata2_i;
  logic [2*DATA_W-1:0] result_o;
  logic                ready_o;

  modport master (
    output start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
    input  result_o, ready_o
  );

  modport slave (
    input  start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
    output result_o, ready_o
  );

endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU, returns {remainder, quotient}.
// Latency: ready_o DATA_W+2 edges after start is accepted, 2 edges for divide-by-zero.
// Backpressure: result held with ready_o while start_i stays high; dropping start_i frees the unit.
// Ports: clk, rst (async, active-high), div (div_unit_if.slave request/response bundle).
`timescale 1ns/1ps
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W,
  parameter int CNT_W  = DIV_CNT_W
) (
  input  logic      clk,
  input  logic      rst,
  div_unit_if.slave div
);

  localparam int W2 = 2 * DATA_W;

  div_state_t        state;
  logic [CNT_W-1:0]  cnt;
  // work[W2-1:DATA_W] = partial remainder, work[DATA_W-1:0] = dividend bits
  // shifting out on the left while quotient bits shift in on the right.
  // The extra top bit holds the remainder bit that shifts out before the trial subtract.
  logic [W2:0]       work;
  logic [DATA_W-1:0] divisor;
  logic              neg_q;
  logic              neg_r;

  logic              op1_neg;
  logic              op2_neg;
  logic [DATA_W-1:0] op1_abs;
  logic [DATA_W-1:0] op2_abs;
  logic [DATA_W+1:0] trial;
  logic              fits;
  logic [W2:0]       work_next;

  always_comb begin
    op1_neg = div.signed_div_i & div.opdata1_i[DATA_W-1];
    op2_neg = div.signed_div_i & div.opdata2_i[DATA_W-1];
    // Negating 0x80..0 gives 0x80..0, which is the correct magnitude when read unsigned.
    op1_abs = op1_neg ? -div.opdata1_i : div.opdata1_i;
    op2_abs = op2_neg ? -div.opdata2_i : div.opdata2_i;
    // Trial subtract of the divisor from the left-shifted partial remainder;
    // the extra guard bit turns into the borrow.
    trial     = work[W2:DATA_W-1] - {2'b00, divisor};
    fits      = ~trial[DATA_W+1];
    work_next = fits ? {trial[DATA_W:0], work[DATA_W-2:0], 1'b1}
                     : {work[W2-1:0], 1'b0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= DIV_FREE;
      cnt          <= '0;
      work         <= '0;
      divisor      <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      div.ready_o  <= 1'b0;
      div.result_o <= '0;
    end else begin
      case (state)
        DIV_FREE: begin
          div.ready_o  <= 1'b0;
          div.result_o <= '0;
          if (div.start_i && !div.annul_i) begin
            if (div.opdata2_i == '0) begin
              state <= DIV_BYZERO;
            end else begin
              work    <= {{(DATA_W+1){1'b0}}, op1_abs};
              divisor <= op2_abs;
              neg_q   <= op1_neg ^ op2_neg;
              neg_r   <= op1_neg;
              cnt     <= '0;
              state   <= DIV_ON;
            end
          end
        end

        DIV_BYZERO: begin
          work  <= '0;
          state <= DIV_END;
        end

        DIV_ON: begin
          if (div.annul_i) begin
            state <= DIV_FREE;
          end else if (cnt == CNT_W'(DATA_W)) begin
            // All quotient bits done: restore signs on the way into END.
            // Remainder takes the dividend's sign, quotient is negative when signs differ.
            work[DATA_W-1:0] <= neg_q ? -work[DATA_W-1:0] : work[DATA_W-1:0];
            work[W2-1:DATA_W] <= neg_r ? -work[W2-1:DATA_W] : work[W2-1:DATA_W];
            cnt   <= '0;
            state <= DIV_END;
          end else begin
            work <= work_next;
            cnt  <= cnt + CNT_W'(1);
          end
        end

        DIV_END: begin
          if (div.start_i) begin
            div.ready_o  <= 1'b1;
            div.result_o <= work[W2-1:0];
          end else begin
            div.ready_o  <= 1'b0;
            div.result_o <= '0;
            state        <= DIV_FREE;
          end
        end

        default: state <= DIV_FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: transaction-level latency/result model plus directed cases.
// Latency: n/a.
// Backpressure: start is held until ready is observed, as EX does.
`timescale 1ns/1ps
module tb_div_unit;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  bit   cmp_en = 1'b0;
  logic [63:0] got;

  div_unit_if #(.DATA_W(32)) dif ();

  div_unit dut (
    .clk (clk),
    .rst (rst),
    .div (dif.slave)
  );

  always #5 clk = ~clk;

  // Reference division straight from the arithmetic definition.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction model: a request accepted at edge N shows ready from N+34
  // (N+2 for a zero divisor) until start drops; annul before the result abandons it.
  bit          m_busy = 1'b0;
  bit          m_byz = 1'b0;
  int          m_wait = 0;
  bit          m_ready = 1'b0;
  logic [63:0] m_res = 64'd0;
  logic [63:0] m_pend = 64'd0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy  <= 1'b0;
      m_ready <= 1'b0;
      m_res   <= 64'd0;
      m_wait  <= 0;
    end else if (m_ready) begin
      if (!dif.start_i) begin
        m_ready <= 1'b0;
        m_res   <= 64'd0;
      end
    end else if (m_busy) begin
      if (dif.annul_i && !m_byz && m_wait >= 2) begin
        m_busy <= 1'b0;
      end else if (m_wait == 1) begin
        m_busy <= 1'b0;
        if (dif.start_i) begin
          m_ready <= 1'b1;
          m_res   <= m_pend;
        end
      end else begin
        m_wait <= m_wait - 1;
      end
    end else if (dif.start_i && !dif.annul_i) begin
      m_busy <= 1'b1;
      m_byz  <= (dif.opdata2_i == 32'd0);
      m_wait <= (dif.opdata2_i == 32'd0) ? 2 : 34;
      m_pend <= ref_div(dif.signed_div_i, dif.opdata1_i, dif.opdata2_i);
    end
  end

  // Cycle-by-cycle compare against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("ready_o", 64'(dif.ready_o), 64'(m_ready));
      chk("result_o", dif.result_o, m_res);
    end
  end

  // Issue one request, wait for ready (bounded), check latency, optionally drop start.
  task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input int exp_lat, input bit drop, input bit scramble);
    int lat;
    @(negedge clk);
    dif.signed_div_i = sgn;
    dif.opdata1_i    = a;
    dif.opdata2_i    = b;
    dif.annul_i      = 1'b0;
    dif.start_i      = 1'b1;
    lat = -1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (dif.ready_o) begin
        lat = c;
        break;
      end
      if (scramble && c == 5) begin
        dif.opdata1_i    = $urandom;
        dif.opdata2_i    = $urandom;
        dif.signed_div_i = ~sgn;
      end
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    got = dif.result_o;
    if (drop) begin
      dif.start_i = 1'b0;
      @(negedge clk);
      chk("ready_drop", 64'(dif.ready_o), 64'd0);
      chk("result_drop", dif.result_o, 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        sgn;
    logic [31:0] a, b;
    int          sel;

    rst = 1'b1;
    dif.start_i = 1'b0;
    dif.annul_i = 1'b0;
    dif.signed_div_i = 1'b0;
    dif.opdata1_i = 32'd0;
    dif.opdata2_i = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset_ready", 64'(dif.ready_o), 64'd0);
    chk("reset_result", dif.result_o, 64'd0);
    rst = 1'b0;
    cmp_en = 1'b1;

    // Pin the reference model against hand-computed values.
    chk("model_divu_100_7", ref_div(1'b0, 32'd100, 32'd7), 64'h00000002_0000000E);
    chk("model_div_m7_2", ref_div(1'b1, 32'hFFFFFFF9, 32'd2), 64'hFFFFFFFF_FFFFFFFD);
    chk("model_div_ovf", ref_div(1'b1, 32'h80000000, 32'hFFFFFFFF), 64'h00000000_80000000);
    chk("model_divu_big", ref_div(1'b0, 32'hFFFFFFF9, 32'd2), 64'h00000001_7FFFFFFC);

    // Directed cases.
    do_div(1'b0, 32'd100, 32'd7, 34, 1'b1, 1'b1);
    chk("divu_100_7", got, 64'h00000002_0000000E);
    do_div(1'b1, 32'hFFFFFFF9, 32'd2, 34, 1'b1, 1'b1);
    chk("div_m7_2", got, 64'hFFFFFFFF_FFFFFFFD);
    do_div(1'b1, 32'd7, 32'd0, 2, 1'b1, 1'b0);
    chk("div_by_zero", got, 64'd0);
    do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 34, 1'b1, 1'b0);
    chk("div_overflow", got, 64'h00000000_80000000);
    do_div(1'b1, 32'd100, 32'hFFFFFFF9, 34, 1'b1, 1'b0);
    chk("div_100_m7", got, 64'h00000002_FFFFFFF2);

    // Annul while iterating: no result ever, then a fresh request completes.
    @(negedge clk);
    dif.signed_div_i = 1'b0;
    dif.opdata1_i = 32'hFFFFFFFF;
    dif.opdata2_i = 32'd3;
    dif.start_i = 1'b1;
    repeat (10) @(negedge clk);
    dif.annul_i = 1'b1;
    dif.start_i = 1'b0;
    @(negedge clk);
    dif.annul_i = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      chk("annul_no_ready", 64'(dif.ready_o), 64'd0);
    end
    do_div(1'b0, 32'd9, 32'd3, 34, 1'b1, 1'b0);
    chk("divu_9_3", got, 64'h00000000_00000003);

    // Annul in FREE suppresses the start.
    @(negedge clk);
    dif.signed_div_i = 1'b0;
    dif.opdata1_i = 32'd50;
    dif.opdata2_i = 32'd5;
    dif.annul_i = 1'b1;
    dif.start_i = 1'b1;
    repeat (4) @(negedge clk);
    chk("annul_free_ready", 64'(dif.ready_o), 64'd0);
    do_div(1'b0, 32'd50, 32'd5, 34, 1'b1, 1'b0);
    chk("divu_50_5", got, 64'h00000000_0000000A);

    // Async reset mid-division.
    @(negedge clk);
    dif.signed_div_i = 1'b0;
    dif.opdata1_i = 32'd1000;
    dif.opdata2_i = 32'd7;
    dif.start_i = 1'b1;
    repeat (15) @(negedge clk);
    #1;
    rst = 1'b1;
    dif.start_i = 1'b0;
    #1;
    chk("rst_mid_ready", 64'(dif.ready_o), 64'd0);
    chk("rst_mid_result", dif.result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    do_div(1'b1, 32'hFFFFFF9C, 32'd7, 34, 1'b0, 1'b0);
    chk("div_m100_7", got, 64'hFFFFFFFE_FFFFFFF2);

    // Async reset while the result is being presented.
    #1;
    rst = 1'b1;
    dif.start_i = 1'b0;
    #1;
    chk("rst_end_ready", 64'(dif.ready_o), 64'd0);
    chk("rst_end_result", dif.result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Randomized requests with biased corner operands.
    for (int i = 0; i < 40; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        3: b = 32'hFFFFFFFF;
        4: a = 32'($urandom_range(0, 100));
        default: ;
      endcase
      do_div(sgn, a, b, (b == 32'd0) ? 2 : 34, 1'b1, 1'b1);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
